// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz from a 25 MHz pixel rate)
// and the 3-bit to 24-bit colour expansion.
package vga_pkg;
  localparam int H_DISPLAY_C = 640;
  localparam int H_FP_C      = 16;
  localparam int H_SYNC_C    = 96;
  localparam int H_BP_C      = 48;
  localparam int V_DISPLAY_C = 480;
  localparam int V_FP_C      = 10;
  localparam int V_SYNC_C    = 2;
  localparam int V_BP_C      = 33;
  localparam int H_TOTAL_C   = H_DISPLAY_C + H_FP_C + H_SYNC_C + H_BP_C;
  localparam int V_TOTAL_C   = V_DISPLAY_C + V_FP_C + V_SYNC_C + V_BP_C;

  function automatic logic [23:0] expand_rgb3(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction
endpackage

// File: rtl/vga_if.sv
// Switch input plus VGA connector / DAC outputs of the test-pattern block.
interface vga_if;
  logic [2:0]  sw;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic [23:0] rgb24;
  logic        video_on;
  logic        p_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;

  modport master (input sw, output hsync, vsync, rgb, rgb24, video_on, p_tick, pixel_x, pixel_y);
  modport slave  (output sw, input hsync, vsync, rgb, rgb24, video_on, p_tick, pixel_x, pixel_y);
endinterface

// File: rtl/vga_sync_gen.sv
// Pixel divider, horizontal/vertical counters and registered sync decode.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_C,
  parameter int H_FP      = H_FP_C,
  parameter int H_SYNC    = H_SYNC_C,
  parameter int H_BP      = H_BP_C,
  parameter int V_DISPLAY = V_DISPLAY_C,
  parameter int V_FP      = V_FP_C,
  parameter int V_SYNC    = V_SYNC_C,
  parameter int V_BP      = V_BP_C
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick_o,
  output logic       video_on_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [9:0] pixel_x_o,
  output logic [9:0] pixel_y_o
);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] H_END  = 10'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] V_END  = 10'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic       phase_q;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hs_q, hs_d, vs_q, vs_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (phase_q) begin
      if (x_q == H_END) begin
        x_d = '0;
        y_d = (y_q == V_END) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Sync decoded from the next counts so the registers line up with x_q/y_q
    hs_d = !((x_d >= HS_BEG) && (x_d <= HS_END));
    vs_d = !((y_d >= VS_BEG) && (y_d <= VS_END));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      phase_q <= ~phase_q;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign p_tick_o   = phase_q;
  assign hsync_o    = hs_q;
  assign vsync_o    = vs_q;
  assign pixel_x_o  = x_q;
  assign pixel_y_o  = y_q;
  assign video_on_o = (x_q < H_VIS) && (y_q < V_VIS);
endmodule

// File: rtl/vga_test_pattern.sv
// Solid full-screen colour from three switches over VGA timing, with a
// 24-bit expanded copy of the blanked colour for a DAC.
module vga_test_pattern
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_C,
  parameter int H_FP      = H_FP_C,
  parameter int H_SYNC    = H_SYNC_C,
  parameter int H_BP      = H_BP_C,
  parameter int V_DISPLAY = V_DISPLAY_C,
  parameter int V_FP      = V_FP_C,
  parameter int V_SYNC    = V_SYNC_C,
  parameter int V_BP      = V_BP_C
) (
  input  logic  clk,
  input  logic  reset,
  vga_if.master bus
);
  logic       video_on;
  logic [2:0] rgb_q, rgb_d, rgb;

  vga_sync_gen #(
    .H_DISPLAY(H_DISPLAY), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISPLAY(V_DISPLAY), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .p_tick_o  (bus.p_tick),
    .video_on_o(video_on),
    .hsync_o   (bus.hsync),
    .vsync_o   (bus.vsync),
    .pixel_x_o (bus.pixel_x),
    .pixel_y_o (bus.pixel_y)
  );

  // Colour is sampled every clk, not per pixel, so switch changes land mid-line
  assign rgb_d = bus.sw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign rgb          = video_on ? rgb_q : 3'b000;
  assign bus.video_on = video_on;
  assign bus.rgb      = rgb;
  assign bus.rgb24    = expand_rgb3(rgb);
endmodule

// File: tb/tb_vga_test_pattern.sv
// Randomized check of vga_test_pattern (reduced timing) against a
// position-from-elapsed-clocks model, plus literal timing/colour pins.
module tb_vga_test_pattern;
  localparam int HD = 20, HFP = 2, HS = 4, HBP = 3;
  localparam int VD = 10, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HD + HFP + HS + HBP;  // 29
  localparam int VT = VD + VFP + VS + VBP;  // 17

  logic clk = 1'b0;
  logic reset;
  vga_if bus ();

  vga_test_pattern #(
    .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  int nvec = 0, nerr = 0;
  int k = 0;              // clk edges since reset release
  int mx, my;             // model pixel position
  logic [2:0] mreg = '0;  // model colour register
  int hf1, hr1, hf2, vf1, vr1, wrap_k;
  logic hs_prev, vs_prev;
  logic [23:0] tbl [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                           24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at k=%0d: got %0h, want %0h", name, k, act, exp);
    end
  endtask

  task automatic arm();
    hf1 = -1; hr1 = -1; hf2 = -1; vf1 = -1; vr1 = -1; wrap_k = -1;
    hs_prev = 1'b1; vs_prev = 1'b1;
  endtask

  // One clock: advance the model by the edge just seen, then compare everything.
  task automatic step();
    int ticks, pos;
    logic von;
    logic [2:0] ergb;
    logic [23:0] e24;
    @(negedge clk);
    if (reset) begin k = 0; mreg = '0; end
    else begin k++; mreg = bus.sw; end
    ticks = k / 2;
    pos   = ticks % (HT * VT);
    mx    = pos % HT;
    my    = pos / HT;
    von   = (mx < HD) && (my < VD);
    ergb  = von ? mreg : 3'b000;
    e24   = '0;
    for (int b = 0; b < 3; b++) if (ergb[b]) e24 |= 24'hFF << (8 * b);
    chk("pixel_x", 32'(bus.pixel_x), 32'(mx));
    chk("pixel_y", 32'(bus.pixel_y), 32'(my));
    chk("p_tick", 32'(bus.p_tick), 32'(k % 2));
    chk("hsync", 32'(bus.hsync), 32'(!(mx >= HD + HFP && mx < HD + HFP + HS)));
    chk("vsync", 32'(bus.vsync), 32'(!(my >= VD + VFP && my < VD + VFP + VS)));
    chk("video_on", 32'(bus.video_on), 32'(von));
    chk("rgb", 32'(bus.rgb), 32'(ergb));
    chk("rgb24", 32'(bus.rgb24), 32'(e24));
    if (!reset) begin
      if (hs_prev && !bus.hsync) begin
        if (hf1 < 0) hf1 = k; else if (hf2 < 0) hf2 = k;
      end
      if (!hs_prev && bus.hsync && hr1 < 0) hr1 = k;
      if (vs_prev && !bus.vsync && vf1 < 0) vf1 = k;
      if (!vs_prev && bus.vsync && vr1 < 0) vr1 = k;
      if (k > 2 && bus.pixel_x == 0 && bus.pixel_y == 0 && wrap_k < 0) wrap_k = k;
      hs_prev = bus.hsync;
      vs_prev = bus.vsync;
    end
  endtask

  initial begin
    int guard;
    reset  = 1'b1;
    bus.sw = 3'($urandom_range(0, 7));
    #3;
    repeat (3) step();

    // Random colour traffic over three frames
    reset = 1'b0;
    arm();
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 3) == 0) bus.sw = 3'($urandom_range(0, 7));
    end
    chk("hsync_fall_clk", 32'(hf1), 32'd44);
    chk("hsync_low_clk", 32'(hr1 - hf1), 32'd8);
    chk("line_period_clk", 32'(hf2 - hf1), 32'd58);
    chk("vsync_fall_clk", 32'(vf1), 32'd696);
    chk("vsync_low_clk", 32'(vr1 - vf1), 32'd116);
    chk("frame_wrap_clk", 32'(wrap_k), 32'd986);

    // Expansion sweep inside the visible area
    for (int c = 0; c < 8; c++) begin
      guard = 0;
      while (!(mx < HD - 3 && my < VD) && guard < 2000) begin step(); guard++; end
      chk("sweep_wait", 32'(guard < 2000), 32'd1);
      bus.sw = 3'(c);
      step();
      chk("sweep_rgb", 32'(bus.rgb), 32'(c));
      chk("sweep_rgb24", 32'(bus.rgb24), 32'(tbl[c]));
    end

    // Blanking literal: hold a colour and wait for the horizontal porch
    bus.sw = 3'b101;
    guard = 0;
    while (!(mx >= HD && my < VD) && guard < 2000) begin step(); guard++; end
    chk("blank_wait", 32'(guard < 2000), 32'd1);
    chk("blank_rgb24", 32'(bus.rgb24), 32'h0);

    // Asynchronous reset mid-frame
    guard = 0;
    while (!(mx == 10 && my == 5) && guard < 2000) begin step(); guard++; end
    chk("midrst_wait", 32'(guard < 2000), 32'd1);
    chk("midrst_pre_rgb24", 32'(bus.rgb24), 32'hFF00FF);
    #2 reset = 1'b1;
    #1;
    chk("midrst_x", 32'(bus.pixel_x), 32'd0);
    chk("midrst_y", 32'(bus.pixel_y), 32'd0);
    chk("midrst_rgb", 32'(bus.rgb), 32'd0);
    chk("midrst_hsync", 32'(bus.hsync), 32'd1);
    chk("midrst_vsync", 32'(bus.vsync), 32'd1);
    repeat (2) step();
    reset = 1'b0;
    arm();
    for (int i = 0; i < 1200; i++) begin
      step();
      if ($urandom_range(0, 7) == 0) bus.sw = 3'($urandom_range(0, 7));
    end
    chk("rst2_hsync_fall_clk", 32'(hf1), 32'd44);
    chk("rst2_hsync_low_clk", 32'(hr1 - hf1), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vga_test_pattern.md
# vga_test_pattern

Generates 640x480 @ 60 Hz VGA timing from a 50 MHz system clock and drives a solid full-screen colour selected by three switches. It also expands the 3-bit colour into a 24-bit RGB word for a DAC-style output. The block sits at the top of the display path, between the board switches and the VGA connector.

## Interface

Parameters:
- `H_DISPLAY`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync pulse width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_DISPLAY`, default 480: visible lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync pulse width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.

Ports (the design uses one clock; reset is asynchronous and active-high):
- `clk`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: asynchronous, active-high.
- `sw`, in, 3: colour select as {R,G,B}.
- `hsync`, out, 1: horizontal sync, active low.
- `vsync`, out, 1: vertical sync, active low.
- `rgb`, out, 3: pixel colour {R,G,B}.
- `rgb24`, out, 24: expanded colour, {R[7:0],G[7:0],B[7:0]}.
- `video_on`, out, 1: high while the current pixel is in the visible area.
- `p_tick`, out, 1: pixel-rate enable, one clk wide.
- `pixel_x`, out, 10: current horizontal count.
- `pixel_y`, out, 10: current vertical count.

## Operation

- Pixel divider: a 1-bit phase register toggles every clk. `p_tick` = 1 when phase = 1, giving a 25 MHz pixel rate.
- Horizontal counter `pixel_x`:
  - Range 0..799 (H_TOTAL = sum of the horizontal parameters).
  - Increments on each `p_tick`.
  - Wraps from 799 to 0.
- Vertical counter `pixel_y`:
  - Range 0..524.
  - Increments on `p_tick` when `pixel_x` = 799.
  - Wraps from 524 to 0 on that same tick.
- `hsync` = 0 when 656 ≤ `pixel_x` ≤ 751, otherwise 1.
- `vsync` = 0 when 490 ≤ `pixel_y` ≤ 491, otherwise 1.
- `video_on` = (`pixel_x` < 640) && (`pixel_y` < 480).
- Colour register: `rgb_reg` captures `sw` on every clk; it is not gated by `p_tick`.
- `rgb` = `video_on` ? `rgb_reg` : 3'b000.
- Colour expansion (the decoder function):
  - `rgb24[23:16]` = {8{rgb[2]}}.
  - `rgb24[15:8]` = {8{rgb[1]}}.
  - `rgb24[7:0]` = {8{rgb[0]}}.
- Example expansions: 3'b101 gives 24'hFF00FF; 3'b000 gives 24'h000000.

## Timing

- Reset state: phase = 0, `pixel_x` = 0, `pixel_y` = 0, `hsync` = 1, `vsync` = 1, `rgb_reg` = 0. As a result, `rgb` = 0, `rgb24` = 0, `video_on` = 1 and `p_tick` = 0 during reset.
- `hsync` and `vsync` are registers. Their next values are decoded from the next counter values, so the sync outputs are cycle-aligned with `pixel_x`/`pixel_y`.
- `video_on`, `rgb` and `rgb24` are combinational from registers; there is no extra pipeline stage.
- Colour latency: `sw` to `rgb` is 1 clk while `video_on` = 1.
- First `p_tick` occurs on the 2nd rising edge after reset deasserts. `pixel_x` = 1 after that edge.
- Period figures:
  - Line period: 800 ticks = 1600 clk.
  - hsync low: 96 ticks = 192 clk.
  - Frame period: 525 lines = 840,000 clk.
  - vsync low: 2 lines = 3200 clk.
- Horizontal and vertical wrap occur on the same tick at (799, 524) → (0, 0).
- Reset mid-frame clears all state immediately (asynchronously). Counting restarts from (0, 0) after release.
- A `sw` change mid-line takes effect on the next clk. There is no frame-boundary synchronisation.

## Structure

- Shared package `vga_pkg` holds:
  - The timing constants (640/16/96/48, 480/10/2/33) and the derived totals (H_TOTAL = 800, V_TOTAL = 525).
  - A function `expand_rgb3`, 3-bit to 24-bit.
- One sub-module, `vga_sync_gen`, contains the divider, both counters, the sync registers and `video_on`.
- The top level adds the colour register, the blanking mux and the expansion.

## Test plan

- Reset check: hold `reset` = 1 for 3 clk → `hsync` = 1, `vsync` = 1, `rgb` = 0, `rgb24` = 0, `pixel_x` = `pixel_y` = 0.
- Horizontal timing: `sw` = 3'b000; release reset; measure `hsync` → falling edge 1312 clk after release (tick 656), low for 192 clk, period 1600 clk.
- Vertical timing: run one frame → `vsync` low for 3200 clk starting at line 490; frame period 840,000 clk; counters return to (0, 0) after (799, 524).
- Colour during active area: `sw` = 3'b101 → 1 clk later `rgb` = 3'b101, `rgb24` = 24'hFF00FF. During blanking (`pixel_x` ≥ 640 or `pixel_y` ≥ 480) → `rgb` = 0, `rgb24` = 0.
- Expansion sweep: step `sw` through all 8 codes in the active area → `rgb24` byte = FF/00 per bit (e.g. 3'b010 gives 24'h00FF00, 3'b111 gives 24'hFFFFFF).
- Mid-frame reset: assert `reset` at `pixel_x` = 300, `pixel_y` = 200 → `pixel_x`, `pixel_y` and `rgb` go to 0 immediately and `hsync`/`vsync` go to 1. After release, timing matches the horizontal-timing scenario.
